// File: rtl/turn_sequencer.sv
// turn_sequencer: game-level turn controller for the pool table.
// Sequences aim, launch, roll and evaluation; keeps score and turn.
module turn_sequencer #(
  parameter int NUM_BALLS          = 4,
  parameter int SETTLE_FRAMES      = 8,
  parameter int WIN_SCORE          = 3,
  parameter int AIM_TIMEOUT_FRAMES = 900
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 enterKey,
  input  logic [NUM_BALLS-1:0] ballStopped,
  input  logic [NUM_BALLS-1:0] ballKilled,
  output logic                 startOfTurn,
  output logic                 initialLocation,
  output logic                 currentPlayer,
  output logic [3:0]           score0,
  output logic [3:0]           score1,
  output logic                 gameOver,
  output logic [2:0]           state
);

  localparam int AW = $clog2(AIM_TIMEOUT_FRAMES);
  localparam int SW = $clog2(SETTLE_FRAMES + 1);
  localparam int CW = $clog2(NUM_BALLS + 1);

  localparam logic [2:0] S_RESPAWN  = 3'd0;
  localparam logic [2:0] S_AIM      = 3'd1;
  localparam logic [2:0] S_LAUNCH   = 3'd2;
  localparam logic [2:0] S_ROLL     = 3'd3;
  localparam logic [2:0] S_EVAL     = 3'd4;
  localparam logic [2:0] S_GAMEOVER = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [AW-1:0]        aim_q, aim_d;
  logic                 launch_q, launch_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [NUM_BALLS-1:0] snap_q, snap_d;
  logic                 enter_q, enter_d;
  logic                 player_q, player_d;
  logic [3:0]           score0_q, score0_d;
  logic [3:0]           score1_q, score1_d;
  logic                 sot_q, sot_d;
  logic                 init_q, init_d;
  logic                 go_q, go_d;

  logic                 rise;
  logic                 rest;
  logic                 all_obj;
  logic                 win;
  logic [NUM_BALLS-1:0] new_pot;
  logic [CW-1:0]        n_obj;
  logic [3:0]           s0_add, s1_add;
  logic [3:0]           s0_eval, s1_eval;

  // Object balls only; the white ball (bit 0) never scores.
  function automatic logic [CW-1:0] obj_count(
    input logic [NUM_BALLS-1:0] v
  );
    logic [CW-1:0] c;
    c = '0;
    for (int i = 1; i < NUM_BALLS; i++)
      c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] sat_add(
    input logic [3:0]    a,
    input logic [CW-1:0] b
  );
    logic [4:0] s;
    s = {1'b0, a} + 5'(b);
    return (s > 5'd15) ? 4'hF : s[3:0];
  endfunction

  assign rise    = enterKey & ~enter_q;
  assign rest    = &(ballStopped | ballKilled);
  assign all_obj = &ballKilled[NUM_BALLS-1:1];
  assign new_pot = ballKilled & ~snap_q;
  assign n_obj   = obj_count(new_pot);
  assign s0_add  = sat_add(score0_q, n_obj);
  assign s1_add  = sat_add(score1_q, n_obj);

  // Points go to the shooter even on a scratch.
  assign s0_eval = player_q ? score0_q : s0_add;
  assign s1_eval = player_q ? s1_add : score1_q;

  assign win = (32'(s0_eval) >= WIN_SCORE) ||
               (32'(s1_eval) >= WIN_SCORE) ||
               all_obj;

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_RESPAWN;
      aim_q    <= '0;
      launch_q <= 1'b0;
      settle_q <= '0;
      snap_q   <= '0;
      enter_q  <= 1'b0;
      player_q <= 1'b0;
      score0_q <= 4'd0;
      score1_q <= 4'd0;
      sot_q    <= 1'b0;
      init_q   <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      aim_q    <= aim_d;
      launch_q <= launch_d;
      settle_q <= settle_d;
      snap_q   <= snap_d;
      enter_q  <= enter_d;
      player_q <= player_d;
      score0_q <= score0_d;
      score1_q <= score1_d;
      sot_q    <= sot_d;
      init_q   <= init_d;
      go_q     <= go_d;
    end
  end

  // Next state, counters, turn and score update.
  always_comb begin
    state_d  = state_q;
    aim_d    = aim_q;
    launch_d = launch_q;
    settle_d = settle_q;
    snap_d   = snap_q;
    enter_d  = enterKey;
    player_d = player_q;
    score0_d = score0_q;
    score1_d = score1_q;

    if (state_q != S_AIM)    aim_d    = '0;
    if (state_q != S_LAUNCH) launch_d = 1'b0;
    if (state_q != S_ROLL)   settle_d = '0;

    unique case (state_q)
      S_RESPAWN: begin
        // Stay until the respawn pulse has been issued.
        if (init_q)
          state_d = S_AIM;
      end
      S_AIM: begin
        if (rise) begin
          snap_d  = ballKilled;
          aim_d   = '0;
          state_d = S_LAUNCH;
        end else if (startOfFrame) begin
          if (aim_q == AW'(AIM_TIMEOUT_FRAMES - 1)) begin
            player_d = ~player_q;
            aim_d    = '0;
          end else begin
            aim_d = aim_q + 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        if (startOfFrame) begin
          if (launch_q)
            state_d = S_ROLL;
          else
            launch_d = 1'b1;
        end
      end
      S_ROLL: begin
        if (startOfFrame) begin
          if (!rest)
            settle_d = '0;
          else if (settle_q == SW'(SETTLE_FRAMES - 1))
            state_d = S_EVAL;
          else
            settle_d = settle_q + 1'b1;
        end
      end
      S_EVAL: begin
        score0_d = s0_eval;
        score1_d = s1_eval;
        if (new_pot[0]) begin
          player_d = ~player_q;
          state_d  = S_RESPAWN;
        end else if (n_obj != '0) begin
          state_d = S_AIM;
        end else begin
          player_d = ~player_q;
          state_d  = S_AIM;
        end
        if (win)
          state_d = S_GAMEOVER;
      end
      S_GAMEOVER: state_d = S_GAMEOVER;
      default:    state_d = S_RESPAWN;
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    sot_d  = (state_d == S_AIM) || (state_d == S_LAUNCH);
    init_d = (state_d == S_RESPAWN);
    go_d   = (state_d == S_GAMEOVER);
  end

  assign state           = state_q;
  assign startOfTurn     = sot_q;
  assign initialLocation = init_q;
  assign currentPlayer   = player_q;
  assign score0          = score0_q;
  assign score1          = score1_q;
  assign gameOver        = go_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed vector table for turn_sequencer,
// plus game-over and asynchronous reset sequences.
module tb_turn_sequencer;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       enterKey;
  logic [3:0] ballStopped;
  logic [3:0] ballKilled;
  logic       startOfTurn;
  logic       initialLocation;
  logic       currentPlayer;
  logic [3:0] score0;
  logic [3:0] score1;
  logic       gameOver;
  logic [2:0] state;

  int n_chk;
  int n_fail;

  turn_sequencer dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .enterKey        (enterKey),
    .ballStopped     (ballStopped),
    .ballKilled      (ballKilled),
    .startOfTurn     (startOfTurn),
    .initialLocation (initialLocation),
    .currentPlayer   (currentPlayer),
    .score0          (score0),
    .score1          (score1),
    .gameOver        (gameOver),
    .state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ent;
    logic       sof;
    logic [3:0] stp;
    logic [3:0] kil;
    int         n;
    logic [2:0] st;
    logic       sot;
    logic       il;
    logic       pl;
    logic [3:0] s0;
    logic [3:0] s1;
    logic       go;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic ent, input logic sof,
    input logic [3:0] stp, input logic [3:0] kil, input int n,
    input logic [2:0] st, input logic sot, input logic il,
    input logic pl, input logic [3:0] s0, input logic [3:0] s1,
    input logic go
  );
    vec_t v;
    v.ent = ent; v.sof = sof; v.stp = stp; v.kil = kil; v.n = n;
    v.st = st; v.sot = sot; v.il = il; v.pl = pl;
    v.s0 = s0; v.s1 = s1; v.go = go;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st,
                         input logic sot, input logic il,
                         input logic pl, input logic [3:0] s0,
                         input logic [3:0] s1, input logic go);
    chk({tag, ".state"}, 8'(state), 8'(st));
    chk({tag, ".startOfTurn"}, 8'(startOfTurn), 8'(sot));
    chk({tag, ".initialLocation"}, 8'(initialLocation), 8'(il));
    chk({tag, ".currentPlayer"}, 8'(currentPlayer), 8'(pl));
    chk({tag, ".score0"}, 8'(score0), 8'(s0));
    chk({tag, ".score1"}, 8'(score1), 8'(s1));
    chk({tag, ".gameOver"}, 8'(gameOver), 8'(go));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    resetN = 1'b0;
    startOfFrame = 1'b0;
    enterKey = 1'b0;
    ballStopped = 4'h0;
    ballKilled = 4'h0;

    // ent sof stp kil n | st sot il pl s0 s1 go
    tbl.push_back(mk(0,0,4'h0,4'h0,  1, 0,0,1,0,0,0,0));
    tbl.push_back(mk(0,0,4'h0,4'h0,  1, 1,1,0,0,0,0,0));
    tbl.push_back(mk(1,0,4'h0,4'h0,  1, 2,1,0,0,0,0,0));
    tbl.push_back(mk(0,1,4'h0,4'h0,  1, 2,1,0,0,0,0,0));
    tbl.push_back(mk(0,1,4'h0,4'h0,  1, 3,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,4'h0,4'h0,  5, 3,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,4'hF,4'h0,  7, 3,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,4'hF,4'h0,  1, 4,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,4'hF,4'h0,  1, 1,1,0,1,0,0,0));
    tbl.push_back(mk(1,0,4'hF,4'h0,  1, 2,1,0,1,0,0,0));
    tbl.push_back(mk(0,1,4'hF,4'h0,  2, 3,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,4'hF,4'h0,  7, 3,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,4'hE,4'h0,  1, 3,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,4'hF,4'h0,  7, 3,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,4'hF,4'h0,  1, 4,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,4'hF,4'h0,  1, 1,1,0,0,0,0,0));
    tbl.push_back(mk(1,0,4'hF,4'h0,  1, 2,1,0,0,0,0,0));
    tbl.push_back(mk(0,1,4'hF,4'h0,  2, 3,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,4'h9,4'h6,  7, 3,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,4'h9,4'h6,  1, 4,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,4'h9,4'h6,  1, 1,1,0,0,2,0,0));
    tbl.push_back(mk(1,0,4'hF,4'h6,  1, 2,1,0,0,2,0,0));
    tbl.push_back(mk(0,1,4'hF,4'h6,  2, 3,0,0,0,2,0,0));
    tbl.push_back(mk(0,1,4'h8,4'h7,  8, 4,0,0,0,2,0,0));
    tbl.push_back(mk(0,0,4'h8,4'h7,  1, 0,0,1,1,2,0,0));
    tbl.push_back(mk(0,0,4'hF,4'h0,  1, 1,1,0,1,2,0,0));
    tbl.push_back(mk(0,1,4'hF,4'h0,899, 1,1,0,1,2,0,0));
    tbl.push_back(mk(0,1,4'hF,4'h0,  1, 1,1,0,0,2,0,0));
    tbl.push_back(mk(0,1,4'hF,4'h0,899, 1,1,0,0,2,0,0));
    tbl.push_back(mk(1,1,4'hF,4'h0,  1, 2,1,0,0,2,0,0));
    tbl.push_back(mk(0,1,4'hF,4'h0,  2, 3,0,0,0,2,0,0));
    tbl.push_back(mk(0,1,4'hD,4'h2,  8, 4,0,0,0,2,0,0));
    tbl.push_back(mk(0,0,4'hD,4'h2,  1, 5,0,0,0,3,0,1));

    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    resetN = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      enterKey     = tbl[i].ent;
      startOfFrame = tbl[i].sof;
      ballStopped  = tbl[i].stp;
      ballKilled   = tbl[i].kil;
      repeat (tbl[i].n) @(negedge clk);
      chk_all($sformatf("v%0d", i), tbl[i].st, tbl[i].sot,
              tbl[i].il, tbl[i].pl, tbl[i].s0, tbl[i].s1, tbl[i].go);
    end

    // GAMEOVER absorbs key presses and frames.
    for (int k = 0; k < 3; k++) begin
      enterKey = 1'b1;
      startOfFrame = 1'b1;
      @(negedge clk);
      enterKey = 1'b0;
      @(negedge clk);
      chk_all($sformatf("go_hold%0d", k), 5, 0, 0, 0, 3, 0, 1);
    end
    startOfFrame = 1'b0;
    ballKilled = 4'h0;

    // Asynchronous reset away from any clock edge.
    #2;
    resetN = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    chk_all("rel_respawn", 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("rel_aim", 1, 1, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game-level controller that sequences the ball motion datapath through aim, launch, roll and evaluation.
- Drives startOfTurn and initialLocation into the white-ball move logic.
- Watches per-ball stop and kill status, keeps per-player score and decides turn hand-over.
- Sits between the keyboard/frame-timing logic and the ball move blocks in the top-level game.

Parameters:
- NUM_BALLS, 4, number of balls; index 0 is the white ball, 1..NUM_BALLS-1 are object balls.
- SETTLE_FRAMES, 8, consecutive frames all balls must be at rest before evaluation.
- WIN_SCORE, 3, score at or above which the game ends.
- AIM_TIMEOUT_FRAMES, 900, frames allowed in aim (30 s at 30 Hz) before the turn passes.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous reset, active low
- startOfFrame  in  1  one-cycle pulse per frame (30 Hz)
- enterKey  in  1  level from keyboard; only its rising edge is used
- ballStopped  in  NUM_BALLS  per-ball "at rest" level; bit0 = white
- ballKilled  in  NUM_BALLS  per-ball "potted/killed" level; sticky until initialLocation
- startOfTurn  out  1  high for the whole AIM state
- initialLocation  out  1  one-cycle pulse that respawns the white ball
- currentPlayer  out  1  0 or 1
- score0  out  4  player 0 score, saturating
- score1  out  4  player 1 score, saturating
- gameOver  out  1  high in GAMEOVER
- state  out  3  state encoding, for debug display

Behaviour:
- Reset (async, resetN=0) values:
  - state=RESPAWN; startOfTurn=0; initialLocation=0; currentPlayer=0; score0=score1=0; gameOver=0.
  - Counters cleared; enterKey edge register cleared; killedSnap=0.
- Encoding: RESPAWN=0, AIM=1, LAUNCH=2, ROLL=3, EVAL=4, GAMEOVER=5. Values 6 and 7 go to RESPAWN next cycle.
- enterKey edge detect: registered copy of enterKey; rise = enterKey & ~enterKey_d.
- RESPAWN:
  - initialLocation=1 for exactly this one cycle; then go to AIM.
  - Aim frame counter cleared.
- AIM:
  - startOfTurn=1 (registered, so it goes high on the cycle AIM is entered).
  - On an enterKey rise: killedSnap<=ballKilled, then go to LAUNCH.
  - Otherwise, each startOfFrame increments the aim counter. When the counter reaches AIM_TIMEOUT_FRAMES-1 on a startOfFrame: toggle currentPlayer, clear the counter, stay in AIM.
  - An enterKey rise and a timeout in the same cycle: enter wins and currentPlayer is unchanged.
- LAUNCH:
  - startOfTurn stays 1 so the move logic consumes the shot.
  - Stays until 2 startOfFrame pulses have been seen, then goes to ROLL with startOfTurn=0.
- ROLL:
  - On each startOfFrame, evaluate rest = &(ballStopped | ballKilled).
  - If rest, the settle counter increments; if not, it clears to 0.
  - When the settle counter reaches SETTLE_FRAMES, go to EVAL.
  - startOfFrame pulses outside ROLL/AIM/LAUNCH are ignored.
- EVAL (exactly one cycle):
  - newPot = ballKilled & ~killedSnap; nObj = popcount(newPot[NUM_BALLS-1:1]).
  - Scratch (newPot[0]=1): no points, toggle currentPlayer, go to RESPAWN.
  - Else if nObj>0: add nObj to the current player's score, saturating at 15; same player, go to AIM.
  - Else: toggle currentPlayer, go to AIM.
  - Scratch together with object pots: the object points are still awarded to the shooter before the toggle.
  - Next state overridden to GAMEOVER when the updated score of either player >= WIN_SCORE, or when all object balls are killed.
  - The evaluation uses the post-add score (same-cycle compare).
- GAMEOVER: gameOver=1, startOfTurn=0; absorbing until reset.
- Reset mid-operation returns to the reset values asynchronously. The first cycle after release is RESPAWN, which pulses initialLocation.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Release reset -> initialLocation high exactly 1 cycle, then state=1 and startOfTurn=1, currentPlayer=0, scores 0.
- AIM, no key, 900 startOfFrame pulses -> currentPlayer=1, still AIM. A rise on the same cycle as the 900th frame instead -> LAUNCH, currentPlayer=0.
- enterKey rise, ballStopped=4'b0000 for 5 frames, then 4'b1111 for 8 frames -> EVAL on the cycle after the 8th frame. No new kills -> currentPlayer toggles, AIM.
  - A single moving frame (4'b1110) at rest-frame 7 -> counter restarts and 8 more frames are needed.
- Shot with ballKilled going 0000->0110 -> score0=2, currentPlayer stays 0, AIM. A pre-killed ball present in the LAUNCH snapshot is not recounted.
- Shot with ballKilled=0001 (white potted) -> no points, currentPlayer toggles, RESPAWN pulses initialLocation.
- score0=2, shot pots 1 ball -> score0=3, GAMEOVER, gameOver=1. enterKey rises are ignored. Async resetN mid-GAMEOVER -> all outputs return to reset values.
